disp_page_sched: RTL

//  Shares the 8-digit scanned 7-segment driver between N_SRC page sources (time, date, alarm, ...).

---
 rtl/disp_pkg.sv | 7 +
 rtl/disp_rr_next.sv | 27 ++
 rtl/disp_page_sched.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display page scheduler.
package disp_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ROTATE, ST_URGENT} state_e;
  localparam int          DIGITS      = 8;
  localparam int          NIB_W       = 4;
  localparam logic [3:0]  BLANK_DFLT  = 4'hF;
endpackage

// File: rtl/disp_rr_next.sv
// Next set bit of mask strictly after cur, wrapping; cur itself is checked last.
// With cur = N_SRC-1 this yields the lowest set bit.
module disp_rr_next #(
  parameter int N_SRC = 4,
  parameter int PW    = $clog2(N_SRC)
) (
  input  logic [PW-1:0]    cur,
  input  logic [N_SRC-1:0] mask,
  output logic [PW-1:0]    nxt,
  output logic             none
);
  logic [PW-1:0] id;

  // Descending offset so the closest candidate is written last and wins.
  always_comb begin
    nxt  = cur;
    none = 1'b1;
    id   = '0;
    for (int i = N_SRC; i >= 1; i--) begin
      id = PW'((int'(cur) + i) % N_SRC);
      if (mask[id]) begin
        nxt  = id;
        none = 1'b0;
      end
    end
  end
endmodule

// File: rtl/disp_page_sched.sv
// Page scheduler for the 8-digit scanned 7-segment driver: rotation, key advance,
// urgent override and per-digit blinking.
module disp_page_sched
  import disp_pkg::*;
#(
  parameter int         N_SRC      = 4,
  parameter int         DWELL_CYC  = 50_000_000,
  parameter int         BLINK_CYC  = 12_500_000,
  parameter logic [3:0] BLANK_CODE = BLANK_DFLT,
  parameter int         PW         = $clog2(N_SRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [32*N_SRC-1:0]   src_data,
  input  logic [8*N_SRC-1:0]    src_blink,
  input  logic [N_SRC-1:0]      src_en,
  input  logic [N_SRC-1:0]      urg_req,
  input  logic                  key_next,
  output logic [31:0]           disp_data,
  output logic [PW-1:0]         cur_page,
  output logic                  page_sw,
  output logic                  urg_active
);
  localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
  localparam logic [PW-1:0] LAST_IDX   = PW'(N_SRC - 1);

  state_e          state, state_nxt;
  logic [PW-1:0]   page_nxt, rot_next, en_low, urg_low;
  logic            rot_none, en_none, urg_none, any_en, any_urg, restart;
  logic [DW-1:0]   dwell_cnt, dwell_nxt;
  logic [BW-1:0]   blink_cnt, blink_nxt;
  logic            blink_ph, ph_nxt, sw_pend, sw_nxt;
  logic [31:0]     pg_data, disp_nxt;
  logic [7:0]      pg_blink;

  disp_rr_next #(.N_SRC(N_SRC), .PW(PW)) u_rot (.cur(cur_page), .mask(src_en),  .nxt(rot_next), .none(rot_none));
  disp_rr_next #(.N_SRC(N_SRC), .PW(PW)) u_en  (.cur(LAST_IDX), .mask(src_en),  .nxt(en_low),   .none(en_none));
  disp_rr_next #(.N_SRC(N_SRC), .PW(PW)) u_urg (.cur(LAST_IDX), .mask(urg_req), .nxt(urg_low),  .none(urg_none));

  assign any_en  = ~(en_none | rot_none);
  assign any_urg = ~urg_none;

  always_comb begin
    state_nxt = state;
    page_nxt  = cur_page;
    restart   = 1'b0;
    case (state)
      ST_IDLE: begin
        page_nxt = '0;
        if (any_urg) begin
          state_nxt = ST_URGENT;
          page_nxt  = urg_low;
        end else if (any_en) begin
          state_nxt = ST_ROTATE;
          page_nxt  = en_low;
        end
      end
      ST_ROTATE: begin
        if (any_urg) begin
          state_nxt = ST_URGENT;
          page_nxt  = urg_low;
        end else if (!any_en) begin
          state_nxt = ST_IDLE;
          page_nxt  = '0;
        end else if (!src_en[cur_page] || key_next || dwell_cnt == DWELL_LAST) begin
          // A sole enabled page lands back on itself but still restarts.
          page_nxt = rot_next;
          restart  = 1'b1;
        end
      end
      ST_URGENT: begin
        if (any_urg) begin
          page_nxt = urg_low;
        end else if (any_en) begin
          state_nxt = ST_ROTATE;
          page_nxt  = en_low;
        end else begin
          state_nxt = ST_IDLE;
          page_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        page_nxt  = '0;
      end
    endcase
    if (state_nxt != state || page_nxt != cur_page) restart = 1'b1;

    dwell_nxt = (restart || state_nxt != ST_ROTATE) ? '0 : dwell_cnt + 1'b1;

    blink_nxt = blink_cnt + 1'b1;
    ph_nxt    = blink_ph;
    if (restart || state_nxt == ST_IDLE) begin
      blink_nxt = '0;
      ph_nxt    = 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_nxt = '0;
      ph_nxt    = ~blink_ph;
    end

    sw_nxt = (page_nxt != cur_page) && (state_nxt != ST_IDLE);

    // Output follows the page/phase being registered this edge, with live source data.
    pg_data  = src_data[32*page_nxt +: 32];
    pg_blink = src_blink[8*page_nxt +: 8];
    disp_nxt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (state_nxt == ST_IDLE || (ph_nxt && pg_blink[i]))
        disp_nxt[NIB_W*i +: NIB_W] = BLANK_CODE;
      else
        disp_nxt[NIB_W*i +: NIB_W] = pg_data[NIB_W*i +: NIB_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_page   <= '0;
      dwell_cnt  <= '0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
      disp_data  <= {DIGITS{BLANK_CODE}};
      sw_pend    <= 1'b0;
      page_sw    <= 1'b0;
      urg_active <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_page   <= page_nxt;
      dwell_cnt  <= dwell_nxt;
      blink_cnt  <= blink_nxt;
      blink_ph   <= ph_nxt;
      disp_data  <= disp_nxt;
      sw_pend    <= sw_nxt;
      page_sw    <= sw_pend;
      urg_active <= (state_nxt == ST_URGENT);
    end
  end
endmodule
